// File: rtl/alert_admin_register_if.sv
// Alert administrator bus: alert inputs and controls from the system side,
// registered alert status back to the display/annunciator logic.
interface alert_admin_register_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8,
  parameter int ID_W  = 2
);
  logic             OE;
  logic [N_CH-1:0]  D;
  logic [N_CH-1:0]  mask;
  logic [N_CH-1:0]  ack;
  logic             cnt_clr;
  logic [N_CH-1:0]  Q;
  logic             any_alert;
  logic [ID_W-1:0]  alert_id;
  logic [CNT_W-1:0] alert_count;

  modport master (
    output OE, D, mask, ack, cnt_clr,
    input  Q, any_alert, alert_id, alert_count
  );

  modport slave (
    input  OE, D, mask, ack, cnt_clr,
    output Q, any_alert, alert_id, alert_count
  );
endinterface

// File: rtl/alert_admin_register.sv
// Debounced, maskable N_CH-channel alert register with sticky/transparent
// pending hold, lowest-index priority id and a saturating new-alert counter.
module alert_admin_register #(
  parameter int N_CH     = 4,
  parameter int DEBOUNCE = 3,
  parameter int STICKY   = 1,
  parameter int CNT_W    = 8,
  parameter int ID_W     = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  alert_admin_register_if.slave bus
);

  localparam int               DB_W    = 4;
  localparam int               SUM_W   = CNT_W + 5;
  localparam logic [DB_W-1:0]  DB_SAT  = DB_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DB_W-1:0]  db_q [N_CH];
  logic [DB_W-1:0]  db_d [N_CH];
  logic [N_CH-1:0]  pend_q, pend_d;
  logic [N_CH-1:0]  q_q, q_d;
  logic             any_q, any_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       n_new;
  logic [SUM_W-1:0] cnt_sum;
  logic             qual;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    pend_d  = pend_q;
    n_new   = '0;
    id_d    = '0;
    cnt_d   = cnt_q;
    cnt_sum = '0;
    qual    = 1'b0;
    for (int i = 0; i < N_CH; i++) begin
      db_d[i] = db_q[i];
      if (bus.mask[i] || bus.D[i])  db_d[i] = '0;
      else if (db_q[i] != DB_SAT)   db_d[i] = db_q[i] + 1'b1;

      // Qualification is the edge the filter reaches saturation, not the level.
      qual = (db_d[i] == DB_SAT) && (db_q[i] != DB_SAT);

      if (bus.mask[i])                        pend_d[i] = 1'b0;
      else if (qual)                          pend_d[i] = 1'b1;
      else if (STICKY != 0) begin
        if (bus.ack[i] && bus.D[i])           pend_d[i] = 1'b0;
      end else if (bus.D[i])                  pend_d[i] = 1'b0;

      n_new = n_new + 5'(pend_d[i] & ~pend_q[i]);
    end

    for (int i = N_CH - 1; i >= 0; i--) begin
      if (pend_d[i]) id_d = ID_W'(i);
    end

    cnt_sum = SUM_W'(cnt_q) + SUM_W'(n_new);
    if (bus.cnt_clr)                      cnt_d = '0;
    else if (cnt_sum > SUM_W'(CNT_MAX))   cnt_d = CNT_MAX;
    else                                  cnt_d = cnt_sum[CNT_W-1:0];

    q_d   = bus.OE ? ~pend_d : '1;
    any_d = bus.OE & (|pend_d);
  end

  // NOTE: state is written with non-blocking '<=' only; the per-channel filter
  // counters are real flops and are cleared by reset like everything else.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_CH; i++) db_q[i] <= '0;
      pend_q <= '0;
      q_q    <= '1;
      any_q  <= 1'b0;
      id_q   <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) db_q[i] <= db_d[i];
      pend_q <= pend_d;
      q_q    <= q_d;
      any_q  <= any_d;
      id_q   <= id_d;
      cnt_q  <= cnt_d;
    end
  end

  assign bus.Q           = q_q;
  assign bus.any_alert   = any_q;
  assign bus.alert_id    = id_q;
  assign bus.alert_count = cnt_q;

endmodule

// File: tb/tb_alert_admin_register.sv
// Vector-table bench for alert_admin_register: three instances (default,
// CNT_W=2, STICKY=0) share stimulus; each vector names the instance it checks.
module tb_alert_admin_register;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       oe;
  logic [3:0] d, mask, ack;
  logic       clr;

  always #5 clk = ~clk;

  alert_admin_register_if #(.N_CH(4), .CNT_W(8), .ID_W(2)) if_a ();
  alert_admin_register_if #(.N_CH(4), .CNT_W(2), .ID_W(2)) if_b ();
  alert_admin_register_if #(.N_CH(4), .CNT_W(8), .ID_W(2)) if_c ();

  assign if_a.OE = oe;  assign if_a.D = d;  assign if_a.mask = mask;
  assign if_a.ack = ack; assign if_a.cnt_clr = clr;
  assign if_b.OE = oe;  assign if_b.D = d;  assign if_b.mask = mask;
  assign if_b.ack = ack; assign if_b.cnt_clr = clr;
  assign if_c.OE = oe;  assign if_c.D = d;  assign if_c.mask = mask;
  assign if_c.ack = ack; assign if_c.cnt_clr = clr;

  alert_admin_register #(.N_CH(4), .DEBOUNCE(3), .STICKY(1), .CNT_W(8), .ID_W(2))
    u_a (.clock(clk), .reset(rst_n), .bus(if_a));
  alert_admin_register #(.N_CH(4), .DEBOUNCE(3), .STICKY(1), .CNT_W(2), .ID_W(2))
    u_b (.clock(clk), .reset(rst_n), .bus(if_b));
  alert_admin_register #(.N_CH(4), .DEBOUNCE(3), .STICKY(0), .CNT_W(8), .ID_W(2))
    u_c (.clock(clk), .reset(rst_n), .bus(if_c));

  // Expected word: {Q[3:0], any_alert, alert_id[1:0], alert_count[7:0]}
  typedef struct {
    string       name;
    int          sel;
    logic        rn;
    logic        oe;
    logic [3:0]  d, mask, ack;
    logic        clr;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    int          sel;
    logic [14:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [14:0] obs(int sel);
    case (sel)
      1:       return {if_b.Q, if_b.any_alert, if_b.alert_id, 8'(if_b.alert_count)};
      2:       return {if_c.Q, if_c.any_alert, if_c.alert_id, if_c.alert_count};
      default: return {if_a.Q, if_a.any_alert, if_a.alert_id, if_a.alert_count};
    endcase
  endfunction

  task automatic check(string name, logic [14:0] act, logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got Q=%b any=%b id=%0d cnt=%0d, want Q=%b any=%b id=%0d cnt=%0d",
               name, act[14:11], act[10], act[9:8], act[7:0],
               exp[14:11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  task automatic add(string n, int sel, logic rn, logic o, logic [3:0] d_, logic [3:0] m_,
                     logic [3:0] a_, logic c_, logic [3:0] q_, logic any_, logic [1:0] id_,
                     logic [7:0] cnt_);
    vecs.push_back('{n, sel, rn, o, d_, m_, a_, c_, {q_, any_, id_, cnt_}});
  endtask

  // Drive at posedge+1, expectation queued, compared at the next posedge+1.
  task automatic apply(vec_t v);
    sb_t item;
    rst_n = v.rn; oe = v.oe; d = v.d; mask = v.mask; ack = v.ack; clr = v.clr;
    sb.push_back('{v.name, v.sel, v.exp});
    @(posedge clk);
    #1;
    item = sb.pop_front();
    check(item.name, obs(item.sel), item.exp);
  endtask

  function automatic logic [7:0] sat3(int k);
    return (k > 3) ? 8'd3 : 8'(k);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    // Default test plan tables
    for (int i = 0; i < 5; i++) add("idle", 0, 1, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0);
    // Debounce with a one-edge glitch
    add("db_l1", 0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("db_l2", 0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("db_gl", 0, 1, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0);
    add("db_r1", 0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("db_r2", 0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("db_q",  0, 1, 1, 4'hB, 0, 0, 0, 4'hB, 1, 2, 1);
    add("db_ack",0, 1, 1, 4'hF, 0, 4'h4, 0, 4'hF, 0, 0, 1);
    // Sticky ack
    add("st_1",  0, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 1);
    add("st_2",  0, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 1);
    add("st_q",  0, 1, 1, 4'hD, 0, 0, 0, 4'hD, 1, 1, 2);
    add("st_ackl",0,1, 1, 4'hD, 0, 4'h2, 0, 4'hD, 1, 1, 2);
    add("st_hold",0,1, 1, 4'hF, 0, 0, 0, 4'hD, 1, 1, 2);
    add("st_ack", 0,1, 1, 4'hF, 0, 4'h2, 0, 4'hF, 0, 0, 2);
    // Simultaneous qualification and priority
    add("sim_1", 0, 1, 1, 4'h6, 0, 0, 0, 4'hF, 0, 0, 2);
    add("sim_2", 0, 1, 1, 4'h6, 0, 0, 0, 4'hF, 0, 0, 2);
    add("sim_q", 0, 1, 1, 4'h6, 0, 0, 0, 4'h6, 1, 0, 4);
    add("sim_a0",0, 1, 1, 4'h7, 0, 4'h1, 0, 4'h7, 1, 3, 4);
    add("sim_a3",0, 1, 1, 4'hF, 0, 4'h8, 0, 4'hF, 0, 0, 4);
    // OE and mask
    add("oe_1",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 4);
    add("oe_2",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 4);
    add("oe_q",  0, 1, 1, 4'hB, 0, 0, 0, 4'hB, 1, 2, 5);
    add("oe_off",0, 1, 0, 4'hB, 0, 0, 0, 4'hF, 0, 2, 5);
    add("oe_on", 0, 1, 1, 4'hB, 0, 0, 0, 4'hB, 1, 2, 5);
    add("msk",   0, 1, 1, 4'hB, 4'h4, 0, 0, 4'hF, 0, 0, 5);
    add("um_1",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 5);
    add("um_2",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 5);
    add("um_q",  0, 1, 1, 4'hB, 0, 0, 0, 4'hB, 1, 2, 6);
    add("clr",   0, 1, 1, 4'hB, 0, 0, 1, 4'hB, 1, 2, 0);
    add("clr_ak",0, 1, 1, 4'hF, 0, 4'h4, 0, 4'hF, 0, 0, 0);
    // State keeps updating while OE=0
    add("hid_1", 0, 1, 0, 4'hD, 0, 0, 0, 4'hF, 0, 0, 0);
    add("hid_2", 0, 1, 0, 4'hD, 0, 0, 0, 4'hF, 0, 0, 0);
    add("hid_q", 0, 1, 0, 4'hD, 0, 0, 0, 4'hF, 0, 1, 1);
    add("hid_on",0, 1, 1, 4'hD, 0, 0, 0, 4'hD, 1, 1, 1);
    add("hid_ak",0, 1, 1, 4'hF, 0, 4'h2, 0, 4'hF, 0, 0, 1);
    // Mask beats set on the qualifying edge
    add("ms_1",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 1);
    add("ms_2",  0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 1);
    add("ms_set",0, 1, 1, 4'hB, 4'h4, 0, 0, 4'hF, 0, 0, 1);
    add("ms_idl",0, 1, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 1);
    // Counter saturation (CNT_W=2)
    add("b_rst", 1, 0, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0);
    for (int k = 1; k <= 5; k++) begin
      add("b_l1", 1, 1, 1, 4'hE, 0, 0, 0, 4'hF, 0, 0, sat3(k - 1));
      add("b_l2", 1, 1, 1, 4'hE, 0, 0, 0, 4'hF, 0, 0, sat3(k - 1));
      add("b_q",  1, 1, 1, 4'hE, 0, 0, 0, 4'hE, 1, 0, sat3(k));
      add("b_ak", 1, 1, 1, 4'hF, 0, 4'h1, 0, 4'hF, 0, 0, sat3(k));
    end
    add("b_c1",  1, 1, 1, 4'hE, 0, 0, 0, 4'hF, 0, 0, 3);
    add("b_c2",  1, 1, 1, 4'hE, 0, 0, 0, 4'hF, 0, 0, 3);
    add("b_clrq",1, 1, 1, 4'hE, 0, 0, 1, 4'hE, 1, 0, 0);
    // Transparent mode (STICKY=0)
    add("c_rst", 2, 0, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0);
    add("c_1",   2, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 0);
    add("c_2",   2, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 0);
    add("c_q",   2, 1, 1, 4'hD, 0, 0, 0, 4'hD, 1, 1, 1);
    add("c_ackl",2, 1, 1, 4'hD, 0, 4'h2, 0, 4'hD, 1, 1, 1);
    add("c_rel", 2, 1, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 1);
    add("c_r1",  2, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 1);
    add("c_gl",  2, 1, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 1);
    add("c_r2",  2, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 1);
    add("c_r3",  2, 1, 1, 4'hD, 0, 0, 0, 4'hF, 0, 0, 1);
    add("c_rq",  2, 1, 1, 4'hD, 0, 0, 0, 4'hD, 1, 1, 2);
    // Async reset mid-pending discards the filter state
    add("r_rst", 0, 0, 1, 4'hF, 0, 0, 0, 4'hF, 0, 0, 0);
    add("r_1",   0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("r_2",   0, 1, 1, 4'hB, 0, 0, 0, 4'hF, 0, 0, 0);
    add("r_q",   0, 1, 1, 4'hB, 0, 0, 0, 4'hB, 1, 2, 1);

    // Reset held with random inputs
    rst_n = 1'b0; oe = 1'b1; d = 4'hF; mask = '0; ack = '0; clr = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      for (int s = 0; s < 3; s++) check("in_reset", obs(s), {4'hF, 1'b0, 2'd0, 8'd0});
      d = 4'($urandom); oe = 1'($urandom); ack = 4'($urandom);
    end

    foreach (vecs[i]) apply(vecs[i]);

    // Assert reset between edges while channel 2 is pending
    #2 rst_n = 1'b0;
    #1 check("async_rst", obs(0), {4'hF, 1'b0, 2'd0, 8'd0});
    @(posedge clk);
    #1;
    apply('{"pr_1", 0, 1'b1, 1'b1, 4'hB, 4'h0, 4'h0, 1'b0, {4'hF, 1'b0, 2'd0, 8'd0}});
    apply('{"pr_2", 0, 1'b1, 1'b1, 4'hB, 4'h0, 4'h0, 1'b0, {4'hF, 1'b0, 2'd0, 8'd0}});
    apply('{"pr_q", 0, 1'b1, 1'b1, 4'hB, 4'h0, 4'h0, 1'b0, {4'hB, 1'b1, 2'd2, 8'd1}});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alert_admin_register.md
Name: alert_admin_register

Overview:
Parameterised successor to the 4-bit alert administrator register. Captures N_CH active-low alert lines and debounces each one. Holds each alert as pending, in sticky or transparent mode, until it is acknowledged. Reports pending alerts on active-low registered outputs gated by OE, with a lowest-index priority id and a saturating new-alert event counter; feeds the alarm display/annunciator logic.

Parameters:
N_CH, 4, number of alert channels (1..16).
DEBOUNCE, 3, consecutive low samples required to accept an alert (1..15; 1 = no filtering).
STICKY, 1, 1 = pending held until acknowledged; 0 = pending follows the debounced input.
CNT_W, 8, width of the new-alert event counter.
ID_W, 2, width of alert_id; must equal max(1, clog2(N_CH)).

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
OE  input  1  output enable; 0 forces Q all-ones and any_alert low
D  input  N_CH  raw alert inputs, active-low (0 = alert condition)
mask  input  N_CH  1 = channel disabled
ack  input  N_CH  per-channel acknowledge (sticky mode only)
cnt_clr  input  1  synchronous clear of alert_count
Q  output  N_CH  registered alert outputs, active-low (1 = idle)
any_alert  output  1  registered; 1 when OE=1 and any channel pending
alert_id  output  ID_W  registered; lowest index of pending channels, 0 when none
alert_count  output  CNT_W  registered saturating count of newly pending alerts

Behaviour:
- Reset (reset=0, async): all debounce counters 0, pending 0, Q all-ones, any_alert 0, alert_id 0, alert_count 0. Reset mid-debounce or mid-pending discards all state. Release takes effect on the next edge.
- Debounce, per channel, per edge: if mask[i]=1 or D[i]=1 the counter goes to 0. Otherwise it increments and saturates at DEBOUNCE. A channel becomes "qualified" on the edge where the counter reaches DEBOUNCE.
- Latency: with D[i] low at DEBOUNCE consecutive edges, pending[i] is set on the DEBOUNCE-th edge, and Q[i]=0 is visible right after it. DEBOUNCE=1 gives a one-edge capture, like the original register.
- A single-edge high glitch on D[i] before qualification restarts the count.
- Sticky (STICKY=1):
  - pending[i] sets on qualification.
  - pending[i] clears on an edge with ack[i]=1 and D[i]=1.
  - ack[i]=1 while D[i]=0 is ignored and the alert stays pending.
  - Ack and a new qualification on the same edge: set wins.
- Transparent (STICKY=0): pending[i] sets on qualification and clears on the first edge with D[i]=1 (no release debounce). ack is ignored.
- mask[i]=1: pending[i] cleared on that edge, takes priority over set. Counting restarts from 0 after unmask.
- Output register, loaded every edge from next-state pending and the current OE:
  - OE=1: Q = ~pending.
  - OE=0: Q = all-ones and any_alert = 0.
- OE does not freeze or clear internal state: pending, counters and alert_count keep updating. Raising OE shows current pending after the next edge.
- alert_id: lowest i with next-state pending[i]=1, else 0. It is independent of OE.
- alert_count: increments by the number of channels whose pending goes 0->1 on that edge (popcount; multiple simultaneous). Saturates at 2^CNT_W-1 and never wraps. cnt_clr=1 loads 0 and wins over a simultaneous increment.
- All outputs change only on clock edges or async reset; no combinational path from inputs to outputs.

Test Plan:
1. Reset then idle: hold reset=0 with random D. After release, D=all-ones and OE=1 for 5 edges -> Q=4'b1111, any_alert=0, alert_id=0, alert_count=0.
2. Debounce: DEBOUNCE=3, OE=1, D[2] low for 2 edges, high 1 edge, then low 3 edges -> Q[2] stays 1 until the 3rd edge of the final run, then Q=4'b1011, alert_id=2, alert_count=1.
3. Sticky ack: channel 1 pending; ack[1]=1 with D[1]=0 -> Q[1] stays 0. D[1]=1 then ack[1]=1 for one edge -> Q[1]=1 after that edge, any_alert=0.
4. Simultaneous and priority: D[3] and D[0] qualify on the same edge -> Q=4'b0110, alert_id=0, alert_count +2. ack[0] with D[0] high -> alert_id=3.
5. OE and mask: channel 2 pending, OE=0 -> Q=4'b1111, any_alert=0, alert_id=2. OE=1 -> Q=4'b1011 next edge. mask[2]=1 -> Q=4'b1111. Unmask with D[2] still low -> re-qualifies after 3 edges, alert_count +1.
6. Counter limits: CNT_W=2, generate 5 separate alerts -> alert_count saturates at 3. cnt_clr with a new alert on the same edge -> alert_count=0. Also rerun test 3 with STICKY=0 -> Q[1] releases one edge after D[1] goes high, no ack needed.
